decrypt_engine_p: RTL and testbench

DECRYPT_ENGINE_P -- requirements
Module: decrypt_engine_p

---
 rtl/decrypt_engine_p.sv | 186 ++++++++++++++++++
 tb/tb_decrypt_engine_p.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decrypt_engine_p.sv
// decrypt_engine_p: recovers LFSR tap pattern and seed from a PAD preamble, then decrypts into the plaintext region
module decrypt_engine_p_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);
    logic [DW-1:0] core [0:2**AW-1];
    always_ff @(posedge clk) begin
        if (i_we) core[i_waddr] <= i_wdata;
        o_rdata_a <= core[i_raddr_a];
        o_rdata_b <= core[i_raddr_b];
    end
endmodule

module decrypt_engine_p #(
    parameter int LFSR_W = 6,
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int MSG_LEN = 64,
    parameter int CT_BASE = 64,
    parameter int PT_BASE = 0,
    parameter int PRE_MIN = 7,
    parameter int NUM_PTRN = 6,
    parameter logic [NUM_PTRN*LFSR_W-1:0] TAPS = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter logic [DW-1:0] PAD = 8'h5F
) (
    input  logic                                                clk,
    input  logic                                                init,
    input  logic                                                wr_en,
    input  logic [AW-1:0]                                       waddr,
    input  logic [DW-1:0]                                       data_in,
    input  logic [AW-1:0]                                       raddr,
    output logic [DW-1:0]                                       data_out,
    output logic                                                done,
    output logic                                                match,
    output logic [(NUM_PTRN > 1 ? $clog2(NUM_PTRN) : 1)-1:0]   ptrn_idx,
    output logic [LFSR_W-1:0]                                   seed,
    output logic                                                busy
);
    localparam int PW = NUM_PTRN > 1 ? $clog2(NUM_PTRN) : 1;
    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int KW = $clog2(PRE_MIN);

    typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECRYPT, FILL, DONE, FAIL} state_t;

    state_t            r_state, w_state_n;
    logic [PW-1:0]     r_p, w_p_n;
    logic [KW-1:0]     r_k, w_k_n;
    logic [LFSR_W-1:0] r_s, w_s_n, r_l, w_l_n, w_ln, w_seed;
    logic [CW-1:0]     r_i, w_i_n, r_wp, w_wp_n;
    logic              r_strip, w_strip_n, w_win, w_ewe, w_we;
    logic [AW-1:0]     w_eaddr, w_ewaddr, w_waddr;
    logic [DW-1:0]     w_erd, w_plain, w_ewdata, w_wdata;

    function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x, input logic [PW-1:0] p);
        logic [LFSR_W-1:0] t;
        t = TAPS[32'(p)*LFSR_W +: LFSR_W];
        return {x[LFSR_W-2:0], ^(x & t)};
    endfunction

    function automatic logic [DW-1:0] zext(input logic [LFSR_W-1:0] x);
        logic [DW-1:0] z;
        z = '0;
        z[LFSR_W-1:0] = x;
        return z;
    endfunction

    // the engine owns the write port only while init is low
    assign w_we    = init ? wr_en : w_ewe;
    assign w_waddr = init ? waddr : w_ewaddr;
    assign w_wdata = init ? data_in : w_ewdata;

    decrypt_engine_p_mem #(.DW(DW), .AW(AW)) dm1 (
        .clk(clk), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
        .i_raddr_a(raddr), .o_rdata_a(data_out),
        .i_raddr_b(w_eaddr), .o_rdata_b(w_erd)
    );

    assign done  = (r_state == DONE) || (r_state == FAIL);
    assign match = (r_state == DONE);
    assign busy  = (r_state == SEED) || (r_state == SEARCH) || (r_state == DECRYPT) || (r_state == FILL);

    // w_eaddr is the word needed next cycle, since the engine read port has 1-cycle latency
    always_comb begin
        w_state_n = r_state;
        w_p_n     = r_p;
        w_k_n     = r_k;
        w_s_n     = r_s;
        w_l_n     = r_l;
        w_i_n     = r_i;
        w_wp_n    = r_wp;
        w_strip_n = r_strip;
        w_win     = 1'b0;
        w_ewe     = 1'b0;
        w_ewdata  = PAD;
        w_ewaddr  = AW'(PT_BASE + 32'(r_wp));
        w_eaddr   = AW'(CT_BASE);
        w_ln      = step(r_l, r_p);
        w_plain   = w_erd ^ zext(r_l);
        w_seed    = w_erd[LFSR_W-1:0] ^ PAD[LFSR_W-1:0];
        case (r_state)
            IDLE: w_state_n = SEED;
            SEED: begin
                w_state_n = (w_seed == '0) ? FAIL : SEARCH;
                w_p_n     = '0;
                w_k_n     = KW'(1);
                w_s_n     = w_seed;
                w_l_n     = w_seed;
                w_eaddr   = AW'(CT_BASE + 1);
            end
            SEARCH: begin
                w_eaddr = AW'(CT_BASE + 1);
                w_l_n   = r_s;
                w_k_n   = KW'(1);
                if (w_erd != (PAD ^ zext(w_ln))) begin
                    w_state_n = (r_p == PW'(NUM_PTRN - 1)) ? FAIL : SEARCH;
                    w_p_n     = (r_p == PW'(NUM_PTRN - 1)) ? r_p : r_p + 1'b1;
                end else if (r_k == KW'(PRE_MIN - 1)) begin
                    w_win     = 1'b1;
                    w_eaddr   = AW'(CT_BASE);
                    w_i_n     = '0;
                    w_state_n = DECRYPT;
                end else begin
                    w_eaddr = AW'(CT_BASE + 32'(r_k) + 1);
                    w_k_n   = r_k + 1'b1;
                    w_l_n   = w_ln;
                end
            end
            DECRYPT: begin
                w_eaddr = AW'(CT_BASE + 32'(r_i) + 1);
                w_l_n   = w_ln;
                w_i_n   = r_i + 1'b1;
                if (!(r_strip && w_plain == PAD)) begin
                    w_ewe     = 1'b1;
                    w_ewdata  = w_plain;
                    w_strip_n = 1'b0;
                    w_wp_n    = r_wp + 1'b1;
                end
                if (r_i == CW'(MSG_LEN - 1)) w_state_n = (w_wp_n == CW'(MSG_LEN)) ? DONE : FILL;
            end
            FILL: begin
                w_ewe     = 1'b1;
                w_wp_n    = r_wp + 1'b1;
                w_state_n = (r_wp == CW'(MSG_LEN - 1)) ? DONE : FILL;
            end
            DONE, FAIL: w_state_n = r_state;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_state  <= IDLE;
            r_p      <= '0;
            r_k      <= '0;
            r_s      <= '0;
            r_l      <= '0;
            r_i      <= '0;
            r_wp     <= '0;
            r_strip  <= 1'b1;
            ptrn_idx <= '0;
            seed     <= '0;
        end else begin
            r_state <= w_state_n;
            r_p     <= w_p_n;
            r_k     <= w_k_n;
            r_s     <= w_s_n;
            r_l     <= w_l_n;
            r_i     <= w_i_n;
            r_wp    <= w_wp_n;
            r_strip <= w_strip_n;
            if (w_win) begin
                ptrn_idx <= r_p;
                seed     <= r_s;
            end
        end
    end
endmodule

// File: tb/tb_decrypt_engine_p.sv
// tb_decrypt_engine_p: directed scenarios for the pad-cipher engine, default build plus a 7-bit LFSR build
module tb_decrypt_engine_p;
    logic       clk = 1'b0;
    logic       init_a = 1'b1, init_b = 1'b1, wr_en = 1'b0;
    logic [7:0] waddr = '0, data_in = '0, raddr = '0;
    logic [7:0] dout_a, dout_b;
    logic       done_a, match_a, busy_a, done_b, match_b, busy_b;
    logic [2:0] pidx_a;
    logic [0:0] pidx_b;
    logic [5:0] seed_a;
    logic [6:0] seed_b;
    logic [7:0] ct [64];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    decrypt_engine_p dut_a (
        .clk(clk), .init(init_a), .wr_en(wr_en), .waddr(waddr), .data_in(data_in), .raddr(raddr),
        .data_out(dout_a), .done(done_a), .match(match_a), .ptrn_idx(pidx_a), .seed(seed_a), .busy(busy_a)
    );

    decrypt_engine_p #(.LFSR_W(7), .NUM_PTRN(1), .PRE_MIN(8), .TAPS(7'h60)) dut_b (
        .clk(clk), .init(init_b), .wr_en(wr_en), .waddr(waddr), .data_in(data_in), .raddr(raddr),
        .data_out(dout_b), .done(done_b), .match(match_b), .ptrn_idx(pidx_b), .seed(seed_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] x, input logic [7:0] t, input int w);
        logic [7:0] m;
        m = 8'((1 << w) - 1);
        return {x[6:0], ^(x & t)} & m;
    endfunction

    task automatic build(input string msg, input int pre, input int w, input logic [7:0] t, input logic [7:0] s0);
        logic [7:0] l, p;
        l = s0;
        for (int i = 0; i < 64; i++) begin
            p = (i >= pre && i - pre < msg.len()) ? msg[i - pre] : 8'h5F;
            ct[i] = p ^ l;
            l = lstep(l, t, w);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        waddr = a;
        data_in = d;
    endtask

    task automatic load(input logic [7:0] fill);
        for (int i = 0; i < 64; i++) begin
            wr(8'(64 + i), ct[i]);
            wr(8'(i), fill);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input bit b, input int bound, output int cyc);
        if (b) init_b = 1'b0; else init_a = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(b ? done_b : done_a) && cyc < bound);
    endtask

    task automatic rd(input bit b, input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        raddr = a;
        @(negedge clk);
        d = b ? dout_b : dout_a;
    endtask

    task automatic check_pt(input bit b, input string tag, input string msg, input logic [7:0] fill);
        logic [7:0] d;
        for (int i = 0; i < 64; i++) begin
            rd(b, 8'(i), d);
            check($sformatf("%s[%0d]", tag, i), d, i < msg.len() ? msg[i] : fill);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("rst_done", done_a, 0);
        check("rst_match", match_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_pidx", pidx_a, 0);
        check("rst_seed", seed_a, 0);
        check("rst_done_b", done_b, 0);

        build("Mr_Watson_come_here", 7, 6, 8'h30, 8'h01);
        load(8'hC3);
        run(0, 174, cyc);
        check("s1_done", done_a, 1);
        check("s1_lat", cyc <= 174, 1);
        check("s1_match", match_a, 1);
        check("s1_busy", busy_a, 0);
        check("s1_pidx", pidx_a, 2);
        check("s1_seed", seed_a, 6'h01);
        check_pt(0, "s1_pt", "Mr_Watson_come_here", 8'h5F);
        wr(8'h00, 8'h00);
        @(negedge clk);
        wr_en = 1'b0;
        rd(0, 8'h00, d);
        check("wr_ignored", d, "M");

        init_a = 1'b1;
        @(negedge clk);
        check("clr_done", done_a, 0);
        check("clr_match", match_a, 0);
        build("", 64, 6, 8'h21, 8'h3F);
        load(8'hC3);
        run(0, 174, cyc);
        check("s2_done", done_a, 1);
        check("s2_match", match_a, 1);
        check("s2_pidx", pidx_a, 0);
        check("s2_seed", seed_a, 6'h3F);
        check_pt(0, "s2_pt", "", 8'h5F);

        init_a = 1'b1;
        build("Mr_Watson_come_here", 7, 6, 8'h30, 8'h01);
        load(8'hC3);
        wr(8'd67, ct[3] ^ 8'h40);
        @(negedge clk);
        wr_en = 1'b0;
        run(0, 174, cyc);
        check("s3_done", done_a, 1);
        check("s3_match", match_a, 0);
        check_pt(0, "s3_pt", "", 8'hC3);

        init_a = 1'b1;
        wr(8'd64, 8'h5F);
        @(negedge clk);
        wr_en = 1'b0;
        run(0, 4, cyc);
        check("s4_done", done_a, 1);
        check("s4_match", match_a, 0);
        check("s4_busy", busy_a, 0);
        rd(0, 8'h00, d);
        check("s4_pt0", d, 8'hC3);

        init_a = 1'b1;
        load(8'hC3);
        run(0, 30, cyc);
        check("s5_busy_mid", busy_a, 1);
        check("s5_done_mid", done_a, 0);
        init_a = 1'b1;
        @(negedge clk);
        check("s5_abort_done", done_a, 0);
        check("s5_abort_busy", busy_a, 0);
        run(0, 174, cyc);
        check("s5_done", done_a, 1);
        check("s5_match", match_a, 1);
        check("s5_pidx", pidx_a, 2);
        check("s5_seed", seed_a, 6'h01);
        check_pt(0, "s5_pt", "Mr_Watson_come_here", 8'h5F);

        build("A joke", 8, 7, 8'h60, 8'h55);
        load(8'hC3);
        run(1, 140, cyc);
        check("s6_done", done_b, 1);
        check("s6_match", match_b, 1);
        check("s6_pidx", pidx_b, 0);
        check("s6_seed", seed_b, 7'h55);
        check_pt(1, "s6_pt", "A joke", 8'h5F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
